// File: rtl/fifo_serial_pkg.sv
// Shared types and constants for the FIFO serial transmitter.
// States, data width and bit-counter width used by fifo_serial_tx.
package fifo_serial_pkg;

  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/fifo_serial_tx_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, ticks on terminal count.
// Held at zero while clear is high so every bit starts a full period.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = ~clear & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_tick)
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains the byte FIFO into async serial frames on tx.
// Even parity bit is built only when FIFO_SERIAL_TX_PARITY_EN is defined.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_get,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST =
    BIT_CNT_W'(DATA_W - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bcnt_q, bcnt_d;
  logic                   scnt_q, scnt_d;
  logic                   tx_q, tx_d;
  logic                   bit_tick;
  logic                   idle;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  assign idle     = (state_q == ST_IDLE);
  assign fifo_get = idle & enable & ~fifo_empty & ~rst;
  assign busy     = ~idle;
  assign tx       = tx_q;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (idle),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    tx_d    = tx_q;
    done    = 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (fifo_get) begin
          shift_d = fifo_data;
          state_d = ST_START;
          tx_d    = 1'b0;
          bcnt_d  = '0;
          scnt_d  = 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          par_d   = ^fifo_data;
`endif
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == BIT_LAST) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          if (scnt_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      scnt_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      tx_q    <= tx_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with a FIFO model and a frame scoreboard.
// Expected tx bits are queued at each pop and compared mid-bit.
module tb_fifo_serial_tx;

  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F = (1 + 8 + P + SB) * CPB;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_get;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] fq[$];
  logic       expq[$];
  int         pop_cyc[$];
  int         ncmp = 0;
  int         nerr = 0;
  int         n_pops = 0;
  int         cyc = 0;
  int         off = 0;
  int         done_cyc = -1;
  logic       act = 1'b0;
  logic       pend = 1'b0;
  logic [7:0] tmp;
  int         base;

  fifo_serial_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_get  (fifo_get),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_upd();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_upd();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int k;
    k = 0;
    while (n_pops < target && k < budget) begin
      step();
      k++;
    end
    chk("wait_pop", 32'(n_pops >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    step();
    while ((busy || fq.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk("wait_idle", 32'(busy), 0);
  endtask

  // FIFO read port: pop the head just after the edge that consumed it
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend) begin
      pend = 1'b0;
      tmp = fq.pop_front();
      fifo_upd();
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("get_in_rst", 32'(fifo_get), 0);
      act = 1'b0;
      expq.delete();
    end else begin
      if (act) begin
        off++;
        if (off >= 2 && (off - 2) % CPB == 0 && expq.size() > 0)
          chk("tx_bit", 32'(tx), 32'(expq.pop_front()));
        if (off == F + 1) begin
          chk("bits_left", expq.size(), 0);
          act = 1'b0;
        end
      end
      chk("busy", 32'(busy), 32'(act));
      chk("done", 32'(done), 32'(act && off == F));
      if (done) done_cyc = cyc;
      if (!act) chk("tx_idle", 32'(tx), 1);
      if (fifo_get) begin
        chk("get_empty", 32'(fifo_empty), 0);
        act = 1'b1;
        off = 0;
        n_pops++;
        pop_cyc.push_back(cyc);
        expq.push_back(1'b0);
        for (int i = 0; i < 8; i++) expq.push_back(fq[0][i]);
`ifdef FIFO_SERIAL_TX_PARITY_EN
        expq.push_back(^fq[0]);
`endif
        for (int i = 0; i < SB; i++) expq.push_back(1'b1);
        pend = 1'b1;
      end
    end
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    fifo_upd();
    repeat (3) step();
    rst = 1'b0;

    // idle with empty FIFO
    repeat (100) step();
    chk("t1_pops", n_pops, 0);
    chk("t1_tx", 32'(tx), 1);
    chk("t1_busy", 32'(busy), 0);

    // single byte
    base = n_pops;
    push(8'hA5);
    wait_pops(base + 1, 20);
    wait_idle(3 * F);
    chk("t2_pops", n_pops, base + 1);
    chk("t2_done_lat", done_cyc - pop_cyc[pop_cyc.size()-1], F);

    // back-to-back
    base = n_pops;
    push(8'h00);
    push(8'hFF);
    wait_pops(base + 2, 3 * F);
    wait_idle(3 * F);
    chk("t3_pops", n_pops, base + 2);
    chk("t3_spacing",
        pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], F + 1);

    // enable dropped mid-frame
    base = n_pops;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_pops(base + 1, 20);
    repeat (9) step();
    enable = 1'b0;
    repeat (3 * F) step();
    chk("t4_pops_held", n_pops, base + 1);
    chk("t4_fifo_left", fq.size(), 2);
    chk("t4_busy", 32'(busy), 0);
    enable = 1'b1;
    wait_pops(base + 3, 4 * F);
    wait_idle(3 * F);
    chk("t4_pops", n_pops, base + 3);

    // reset during data bit 3
    base = n_pops;
    push(8'h3C);
    wait_pops(base + 1, 20);
    repeat (17) step();
    chk("t5_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_get_rst", 32'(fifo_get), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_tx", 32'(tx), 1);
    chk("t5_busy", 32'(busy), 0);
    push(8'h5A);
    wait_pops(base + 2, 20);
    wait_idle(3 * F);
    chk("t5_pops", n_pops, base + 2);

`ifdef FIFO_SERIAL_TX_PARITY_EN
    base = n_pops;
    push(8'h07);
    push(8'h03);
    wait_pops(base + 2, 3 * F);
    wait_idle(3 * F);
    chk("t6_pops", n_pops, base + 2);
    chk("t6_spacing",
        pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], 45);
`endif

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
